// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase codes and per-phase duration lookup for the
// two-direction intersection scheduler.
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_ALLRED_1  = 3'd3,
    ST_EW_GREEN  = 3'd4,
    ST_EW_YELLOW = 3'd5,
    ST_ALLRED_2  = 3'd6,
    ST_PED_WALK  = 3'd7
  } phase_e;

  // Emergency hold reports the IDLE code; a separate hold flag tells them apart.
  localparam phase_e ST_EMERG_HOLD = ST_IDLE;

  function automatic int unsigned phase_dur(phase_e s, int unsigned green_sec,
                                            int unsigned yellow_sec, int unsigned allred_sec,
                                            int unsigned ped_sec);
    case (s)
      ST_NS_GREEN, ST_EW_GREEN:   return green_sec;
      ST_NS_YELLOW, ST_EW_YELLOW: return yellow_sec;
      ST_ALLRED_1, ST_ALLRED_2:   return allred_sec;
      ST_PED_WALK:                return ped_sec;
      default:                    return 1;
    endcase
  endfunction

  function automatic logic [2:0] lamp_for(phase_e s, logic is_ew);
    if (s == (is_ew ? ST_EW_GREEN : ST_NS_GREEN))
      return LIGHT_GREEN;
    else if (s == (is_ew ? ST_EW_YELLOW : ST_NS_YELLOW))
      return LIGHT_YELLOW;
    else
      return LIGHT_RED;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_second_tick_gen.sv
// Clock-to-seconds prescaler: emits one tick per CLK_PER_SEC enabled cycles,
// restartable from zero by a synchronous clear.
module second_tick_gen #(
  parameter int CLK_PER_SEC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection phase sequencer: NS/EW green-yellow-allred cycling with a
// pedestrian walk handshake and an emergency all-red override.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CLK_PER_SEC       = 100,
  parameter int CNT_WIDTH         = 8,
  parameter int GREEN_SEC         = 20,
  parameter int YELLOW_SEC        = 3,
  parameter int ALLRED_SEC        = 2,
  parameter int PED_SEC           = 10,
  parameter int LIGHT_STATE_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         ped_req,
  input  logic                         emerg,
  output logic [LIGHT_STATE_WIDTH-1:0] ns_light,
  output logic [LIGHT_STATE_WIDTH-1:0] ew_light,
  output logic                         walk,
  output logic                         ped_ack,
  output logic                         sec_tick,
  output logic [CNT_WIDTH-1:0]         remain,
  output logic [2:0]                   phase
);

  phase_e st, nxt_st;
  logic   hold, nxt_hold;
  logic   leave, expire, enter_walk, ped_pending;

  second_tick_gen #(.CLK_PER_SEC(CLK_PER_SEC)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (leave || hold),
    .tick (sec_tick)
  );

  assign phase      = st;
  assign expire     = sec_tick && (remain == '0);
  assign enter_walk = leave && !nxt_hold && (nxt_st == ST_PED_WALK);

  // Emergency outranks both timer expiry and a pending walk; yellows always finish.
  always_comb begin
    nxt_st   = st;
    nxt_hold = hold;
    leave    = 1'b0;
    if (en) begin
      if (hold) begin
        if (!emerg) begin
          leave    = 1'b1;
          nxt_hold = 1'b0;
          nxt_st   = ST_ALLRED_2;
        end
      end else begin
        case (st)
          ST_IDLE: begin
            leave = 1'b1;
            if (emerg) nxt_hold = 1'b1;
            else       nxt_st   = ST_NS_GREEN;
          end
          ST_NS_GREEN: if (emerg || expire) begin
            leave  = 1'b1;
            nxt_st = ST_NS_YELLOW;
          end
          ST_EW_GREEN: if (emerg || expire) begin
            leave  = 1'b1;
            nxt_st = ST_EW_YELLOW;
          end
          ST_NS_YELLOW, ST_EW_YELLOW: if (expire) begin
            leave = 1'b1;
            if (emerg) begin
              nxt_hold = 1'b1;
              nxt_st   = ST_EMERG_HOLD;
            end else begin
              nxt_st = (st == ST_NS_YELLOW) ? ST_ALLRED_1 : ST_ALLRED_2;
            end
          end
          default: if (emerg) begin
            leave    = 1'b1;
            nxt_hold = 1'b1;
            nxt_st   = ST_EMERG_HOLD;
          end else if (expire) begin
            leave = 1'b1;
            case (st)
              ST_ALLRED_1: nxt_st = ST_EW_GREEN;
              ST_ALLRED_2: nxt_st = ped_pending ? ST_PED_WALK : ST_NS_GREEN;
              default:     nxt_st = ST_NS_GREEN;
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ST_IDLE;
      hold        <= 1'b0;
      ns_light    <= LIGHT_STATE_WIDTH'(LIGHT_RED);
      ew_light    <= LIGHT_STATE_WIDTH'(LIGHT_RED);
      walk        <= 1'b0;
      ped_ack     <= 1'b0;
      remain      <= '0;
      ped_pending <= 1'b0;
    end else begin
      ped_ack <= 1'b0;
      if (leave) begin
        st       <= nxt_st;
        hold     <= nxt_hold;
        ns_light <= LIGHT_STATE_WIDTH'(lamp_for(nxt_st, 1'b0));
        ew_light <= LIGHT_STATE_WIDTH'(lamp_for(nxt_st, 1'b1));
        walk     <= enter_walk;
        remain   <= nxt_hold ? '0 :
                    CNT_WIDTH'(phase_dur(nxt_st, GREEN_SEC, YELLOW_SEC,
                                         ALLRED_SEC, PED_SEC) - 1);
        if (enter_walk) begin
          ped_pending <= 1'b0;
          ped_ack     <= 1'b1;
        end
      end else if (sec_tick) begin
        remain <= remain - 1'b1;
      end
      // A request arriving on the walk entry edge or during the walk is dropped.
      if (en && ped_req && (st != ST_PED_WALK) && !enter_walk)
        ped_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: stimulus queues per-cycle
// expected lamp/timer outputs, a negedge monitor pops and compares them.
module tb_traffic_phase_scheduler;

  localparam int CPS = 4;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic       ack;
    logic       tick;
    logic [7:0] remain;
  } obs_t;

  localparam obs_t RESET_OBS = '{ns: R, ew: R, walk: 1'b0, ack: 1'b0, tick: 1'b0, remain: 8'd0};

  logic       clk = 1'b0, rst, en, ped_req, emerg;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, ped_ack, sec_tick;
  logic [7:0] remain;
  logic       clk_run = 1'b0;

  int   cyc = 0;
  int   pc;
  int   checks = 0;
  int   errors = 0;
  int   q_cyc[$];
  obs_t q_exp[$];

  traffic_phase_scheduler #(
    .CLK_PER_SEC(CPS), .CNT_WIDTH(8), .GREEN_SEC(3), .YELLOW_SEC(2),
    .ALLRED_SEC(1), .PED_SEC(2), .LIGHT_STATE_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ped_req(ped_req), .emerg(emerg),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .ped_ack(ped_ack),
    .sec_tick(sec_tick), .remain(remain), .phase(phase)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t sample();
    return '{ns: ns_light, ew: ew_light, walk: walk, ack: ped_ack, tick: sec_tick, remain: remain};
  endfunction

  task automatic compare(input string name, input int c, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got ns=%b ew=%b walk=%b ack=%b tick=%b rem=%0d, expected ns=%b ew=%b walk=%b ack=%b tick=%b rem=%0d",
               name, c, act.ns, act.ew, act.walk, act.ack, act.tick, act.remain,
               exp.ns, exp.ew, exp.walk, exp.ack, exp.tick, exp.remain);
    end
  endtask

  task automatic push_one(input logic [2:0] ns, input logic [2:0] ew, input logic wk,
                          input logic ack, input logic tk, input int rem);
    q_cyc.push_back(pc);
    q_exp.push_back('{ns: ns, ew: ew, walk: wk, ack: ack, tick: tk, remain: 8'(rem)});
    pc++;
  endtask

  // Queues a timed phase of secs seconds, optionally truncated to ncyc cycles.
  task automatic push_phase(input logic [2:0] ns, input logic [2:0] ew, input logic wk,
                            input int secs, input logic ack_first, input int ncyc);
    int n;
    n = (ncyc > 0) ? ncyc : secs * CPS;
    for (int k = 0; k < n; k++)
      push_one(ns, ew, wk, ack_first && (k == 0), (k % CPS) == CPS - 1, secs - 1 - k / CPS);
  endtask

  task automatic push_cycle();
    push_phase(G, R, 1'b0, 3, 1'b0, 0);
    push_phase(Y, R, 1'b0, 2, 1'b0, 0);
    push_phase(R, R, 1'b0, 1, 1'b0, 0);
    push_phase(R, G, 1'b0, 3, 1'b0, 0);
    push_phase(R, Y, 1'b0, 2, 1'b0, 0);
    push_phase(R, R, 1'b0, 1, 1'b0, 0);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every cycle compares against the expectation stamped for that cycle.
  initial begin
    int   c;
    obs_t e;
    forever begin
      @(negedge clk);
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
        c = q_cyc.pop_front();
        e = q_exp.pop_front();
        if (c < cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL missed_sample cyc=%0d got none, expected check at cyc %0d", cyc, c);
        end else begin
          compare("obs", c, sample(), e);
        end
      end
    end
  end

  initial begin
    #40000;
    $display("[TB] FAIL watchdog cyc=%0d got timeout, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus();
    rst = 1'b1; en = 1'b0; ped_req = 1'b0; emerg = 1'b0;
    #5;
    compare("reset_noclk", cyc, sample(), RESET_OBS);
    rst = 1'b0;
    en  = 1'b1;
    pc  = 1;
    clk_run = 1'b1;

    // Normal cycle, then a cycle carrying a pedestrian request.
    push_cycle();
    push_cycle();
    push_phase(R, R, 1'b1, 2, 1'b1, 0);
    at_cyc(50); ped_req = 1'b1;
    at_cyc(51); ped_req = 1'b0;
    // Request during the walk must not yield a second walk.
    push_cycle();
    at_cyc(99); ped_req = 1'b1;
    at_cyc(100); ped_req = 1'b0;

    // Emergency raised mid-second in EW green.
    push_phase(G, R, 1'b0, 3, 1'b0, 0);
    push_phase(Y, R, 1'b0, 2, 1'b0, 0);
    push_phase(R, R, 1'b0, 1, 1'b0, 0);
    push_phase(R, G, 1'b0, 3, 1'b0, 6);
    push_phase(R, Y, 1'b0, 2, 1'b0, 0);
    for (int k = 0; k < 10; k++) push_one(R, R, 1'b0, 1'b0, 1'b0, 0);
    push_phase(R, R, 1'b0, 1, 1'b0, 0);
    at_cyc(182); emerg = 1'b1;
    at_cyc(200); emerg = 1'b0;

    // Freeze in NS yellow at remain=1.
    push_phase(G, R, 1'b0, 3, 1'b0, 0);
    for (int k = 0; k < 13; k++) push_one(Y, R, 1'b0, 1'b0, 1'b0, 1);
    push_one(Y, R, 1'b0, 1'b0, 1'b1, 1);
    for (int k = 0; k < 3; k++) push_one(Y, R, 1'b0, 1'b0, 1'b0, 0);
    push_one(Y, R, 1'b0, 1'b0, 1'b1, 0);
    push_phase(R, R, 1'b0, 1, 1'b0, 0);
    at_cyc(218); en = 1'b0;
    at_cyc(228); en = 1'b1;

    // Reset mid EW yellow with a pending pedestrian request.
    push_phase(R, G, 1'b0, 3, 1'b0, 0);
    push_phase(R, Y, 1'b0, 2, 1'b0, 3);
    at_cyc(245); ped_req = 1'b1;
    at_cyc(246); ped_req = 1'b0;
    at_cyc(254);
    #1 rst = 1'b1;
    #1 compare("reset_midrun", cyc, sample(), RESET_OBS);
    #1 rst = 1'b0;
    pc = 255;
    push_cycle();
    push_phase(G, R, 1'b0, 3, 1'b0, 4);
  endtask

  task automatic checkOutput();
    at_cyc(310);
    @(negedge clk);
    if (q_cyc.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain got %0d pending expectations, expected 0", q_cyc.size());
    end
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
